// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RISC-V M-extension divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int XLEN_DEF = 32;

  localparam logic [XLEN_DEF-1:0] DIV0_QUOT = {XLEN_DEF{1'b1}};
  localparam logic [XLEN_DEF-1:0] OVF_QUOT  = {1'b1, {(XLEN_DEF-1){1'b0}}};

endpackage

// File: rtl/div_iter_unit_step.sv
// One restoring radix-2 division step; a wider radix can replace this without touching the FSM.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] dq,
  input  logic [XLEN-1:0] dmag,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] dq_next
);

  logic [XLEN:0] trial;
  logic          qbit;

  // The partial remainder stays below dmag, so the shifted value needs only one extra bit.
  assign trial = {rem, dq[XLEN-1]} - {1'b0, dmag};
  assign qbit  = ~trial[XLEN];

  assign rem_next = qbit ? trial[XLEN-1:0] : {rem[XLEN-2:0], dq[XLEN-1]};
  assign dq_next  = {dq[XLEN-2:0], qbit};

endmodule

// File: rtl/div_iter_unit.sv
// Sequential radix-2 divider for DIV/DIVU/REM/REMU with request/response handshakes.
module div_iter_unit
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            unsign_i,
  input  logic            rem_i,
  output logic            resp_valid_o,
  input  logic            resp_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  localparam int CNT_W = $clog2(XLEN);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rem_acc;
  logic [XLEN-1:0]  dq;
  logic [XLEN-1:0]  dmag;
  logic [XLEN-1:0]  result;
  logic             r_sign;
  logic             q_neg;
  logic             want_rem;
  logic             resp_valid;

  logic [XLEN-1:0]  rem_next;
  logic [XLEN-1:0]  dq_next;
  logic             a_sign;
  logic             b_sign;
  logic             div_zero;
  logic             overflow;

  function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (~v + XLEN'(1)) : v;
  endfunction

  assign a_sign   = dividend_i[XLEN-1] & ~unsign_i;
  assign b_sign   = divisor_i[XLEN-1] & ~unsign_i;
  assign div_zero = (divisor_i == '0);
  assign overflow = ~unsign_i && (dividend_i == XLEN'(OVF_QUOT)) && (divisor_i == XLEN'(DIV0_QUOT));

  div_step #(.XLEN(XLEN)) u_step (
    .rem      (rem_acc),
    .dq       (dq),
    .dmag     (dmag),
    .rem_next (rem_next),
    .dq_next  (dq_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rem_acc    <= '0;
      dq         <= '0;
      dmag       <= '0;
      result     <= '0;
      r_sign     <= 1'b0;
      q_neg      <= 1'b0;
      want_rem   <= 1'b0;
      resp_valid <= 1'b0;
    end else if (flush_i) begin
      // Flush wins over accept and response; the pending result is dropped.
      state      <= IDLE;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            r_sign   <= a_sign;
            q_neg    <= a_sign ^ b_sign;
            want_rem <= rem_i;
            if (div_zero) begin
              result     <= rem_i ? dividend_i : XLEN'(DIV0_QUOT);
              resp_valid <= 1'b1;
              state      <= DONE;
            end else if (overflow) begin
              result     <= rem_i ? '0 : XLEN'(OVF_QUOT);
              resp_valid <= 1'b1;
              state      <= DONE;
            end else begin
              dq      <= cond_neg(dividend_i, a_sign);
              dmag    <= cond_neg(divisor_i, b_sign);
              rem_acc <= '0;
              cnt     <= '0;
              state   <= CALC;
            end
          end
        end
        CALC: begin
          rem_acc <= rem_next;
          dq      <= dq_next;
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN-1)) state <= FIX;
        end
        FIX: begin
          // Remainder follows the dividend's sign; quotient follows the sign product.
          result     <= want_rem ? cond_neg(rem_acc, r_sign) : cond_neg(dq, q_neg);
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (resp_ready_i) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state == IDLE);
  assign busy_o       = (state != IDLE);
  assign resp_valid_o = resp_valid;
  assign result_o     = result;

endmodule

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: directed table, corner sequences and random ops vs. an arithmetic model.
module tb_div_iter_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        unsign;
  logic        rem;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] result;
  logic        busy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  div_iter_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .unsign_i     (unsign),
    .rem_i        (rem),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .result_o     (result),
    .busy_o       (busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          u;
    bit          r;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference: ISA division rules expressed with native SV arithmetic.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input bit u, input bit r);
    int sa;
    int sb;
    if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
    if (!u && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
    if (u) return r ? (a % b) : (a / b);
    sa = a;
    sb = b;
    return r ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b, input bit u);
    if (b == 32'd0) return 1;
    if (!u && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Called #1 after a rising edge with the unit idle; the accept edge counts as edge 1.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit u, input bit r,
                        output logic [31:0] res, output int lat);
    dividend  = a;
    divisor   = b;
    unsign    = u;
    rem       = r;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic release_resp();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res;
    logic [31:0] held;
    int          lat;
    int          rises;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          ru;
    bit          rr;
    int          mode;

    vecs[0]  = '{32'd100,        32'd7,          1'b0, 1'b0, 32'd14,         34};
    vecs[1]  = '{32'd100,        32'd7,          1'b0, 1'b1, 32'd2,          34};
    vecs[2]  = '{32'hFFFF_FFF9,  32'd2,          1'b0, 1'b0, 32'hFFFF_FFFD,  34};
    vecs[3]  = '{32'hFFFF_FFF9,  32'd2,          1'b0, 1'b1, 32'hFFFF_FFFF,  34};
    vecs[4]  = '{32'hFFFF_FFFF,  32'd1,          1'b1, 1'b0, 32'hFFFF_FFFF,  34};
    vecs[5]  = '{32'd5,          32'd0,          1'b0, 1'b0, 32'hFFFF_FFFF,  1};
    vecs[6]  = '{32'd5,          32'd0,          1'b0, 1'b1, 32'd5,          1};
    vecs[7]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0, 32'h8000_0000,  1};
    vecs[8]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b1, 32'd0,          1};
    vecs[9]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b1, 32'h8000_0000,  34};
    vecs[10] = '{32'd7,          32'hFFFF_FFFE,  1'b0, 1'b1, 32'd1,          34};
    vecs[11] = '{32'hFFFF_FFF0,  32'd0,          1'b1, 1'b1, 32'hFFFF_FFF0,  1};

    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    dividend = '0; divisor = '0; unsign = 1'b0; rem = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_result",     result,          32'd0);
    check("reset_busy",       32'(busy),       32'd0);
    check("reset_req_ready",  32'(req_ready),  32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].u, vecs[i].r, res, lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      release_resp();
    end

    // Backpressure: result held in DONE while the consumer stalls
    run_op(32'd100, 32'd7, 1'b0, 1'b0, held, lat);
    check("bp_first_result", held, 32'd14);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_result", i), result, held);
      check($sformatf("bp_hold%0d_valid", i), 32'(resp_valid), 32'd1);
      check($sformatf("bp_hold%0d_req_ready", i), 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("bp_release_req_ready", 32'(req_ready), 32'd1);
    check("bp_release_valid",     32'(resp_valid), 32'd0);
    check("bp_release_busy",      32'(busy),       32'd0);

    // Flush during CALC
    dividend = 32'd1000; divisor = 32'd3; unsign = 1'b0; rem = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("flush_busy_before", 32'(busy), 32'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_req_ready", 32'(req_ready),  32'd1);
    check("flush_busy",      32'(busy),       32'd0);
    check("flush_valid",     32'(resp_valid), 32'd0);
    rises = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (resp_valid) rises++;
    end
    check("flush_no_response", 32'(rises), 32'd0);

    // Request presented together with flush in IDLE is ignored
    dividend = 32'd9; divisor = 32'd3; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", 32'(busy), 32'd0);

    run_op(32'd9, 32'd3, 1'b0, 1'b0, res, lat);
    check("post_flush_result",  res,      32'd3);
    check("post_flush_latency", 32'(lat), 32'd34);
    release_resp();

    // Asynchronous reset mid-CALC
    dividend = 32'd100; divisor = 32'd7; unsign = 1'b0; rem = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy",      32'(busy),       32'd0);
    check("async_rst_req_ready", 32'(req_ready),  32'd1);
    check("async_rst_valid",     32'(resp_valid), 32'd0);
    check("async_rst_result",    result,          32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'd20, 32'd4, 1'b0, 1'b0, res, lat);
    check("post_rst_result",  res,      32'd5);
    check("post_rst_latency", 32'(lat), 32'd34);
    release_resp();

    // Random operations against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      mode = $urandom_range(0, 9);
      ra = $urandom;
      rb = $urandom;
      ru = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      if (mode == 0) rb = 32'd0;
      else if (mode == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (mode == 2) rb = 32'($urandom_range(1, 20));
      else if (mode == 3) rb = -32'($urandom_range(1, 20));
      run_op(ra, rb, ru, rr, res, lat);
      check($sformatf("rand%0d_result a=%h b=%h u=%0d r=%0d", i, ra, rb, ru, rr),
            res, ref_div(ra, rb, ru, rr));
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_lat(ra, rb, ru)));
      release_resp();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Sequential radix-2 integer divider implementing RISC-V M-extension DIV/DIVU/REM/REMU.
- Sits beside the EX stage. Accepts one request per operation over a valid/ready handshake, iterates internally, and returns a single 32-bit result over a second valid/ready handshake.
- Handles signed and unsigned operands, divide-by-zero and signed overflow per the ISA.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  abort current operation (pipeline flush)
- req_valid_i  in  1  request present
- req_ready_o  out  1  unit can accept a request
- dividend_i  in  XLEN  numerator (rs1)
- divisor_i  in  XLEN  denominator (rs2)
- unsign_i  in  1  1 = DIVU/REMU, 0 = signed
- rem_i  in  1  1 = return remainder, 0 = return quotient
- resp_valid_o  out  1  result valid
- resp_ready_i  in  1  consumer takes result
- result_o  out  XLEN  quotient or remainder
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, counter=0, all datapath registers 0.
  - resp_valid_o=0, result_o=0, busy_o=0, req_ready_o=1.
  - Reset mid-operation discards all work immediately.
- States:
  - IDLE: req_ready_o=1. On req_valid_i&req_ready_o the operands are latched.
    - Go to DONE if divisor==0 or signed overflow (unsign_i=0, dividend=0x80000000, divisor=0xFFFFFFFF).
    - Otherwise go to CALC with counter=0.
  - CALC: one restoring step per cycle.
    - rem33 = {rem[31:0], dq[31]}. Trial = rem33 - {1'b0, dmag}.
    - If the trial is non-negative: rem = trial and quotient bit = 1. Otherwise keep rem33 and quotient bit = 0.
    - dq shifts left, inserting the quotient bit.
    - Exits to FIX after the 32nd step (counter==XLEN-1).
  - FIX: apply signs and select the quotient or remainder into result_o. Go to DONE.
  - DONE: resp_valid_o=1 and result_o is held stable.
    - resp_ready_i=1 returns to IDLE. No new request is accepted in that same cycle.
    - resp_ready_i=0 holds indefinitely.
- Sign handling:
  - r_sign = dividend[31] & ~unsign_i; d_sign = divisor[31] & ~unsign_i.
  - Magnitudes are two's-complement negated when the sign is set.
  - Quotient is negated if r_sign^d_sign. Remainder is negated if r_sign (remainder takes the dividend's sign).
- Special results (set directly on the accept edge):
  - Divide by zero: quotient=0xFFFFFFFF, remainder=dividend.
  - Overflow: quotient=0x80000000, remainder=0.
- Latency, measured from the accept edge:
  - Normal: resp_valid_o high after exactly 34 edges (32 CALC + 1 FIX + DONE entry).
  - Special: resp_valid_o high after 1 edge.
- flush_i:
  - From any state, the next edge forces IDLE and resp_valid_o=0. The result is never presented.
  - flush_i has priority over both request accept and response handshake.
  - req_valid_i while flush_i=1 in IDLE is not accepted.
- Handshake rules:
  - req_ready_o and busy_o are combinational from state only.
  - result_o changes only on DONE entry. It is not required to reset afterwards.

Decomposition:
- div_pkg:
  - state enum {IDLE, CALC, FIX, DONE}
  - XLEN default
  - constants DIV0_QUOT (all ones) and OVF_QUOT (0x80000000)
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: rem, dq, dmag.
  - Outputs: next rem, next dq.
  - Allows a later unroll to radix-4 without touching the FSM.
- Top level holds the FSM, counter, operand/sign registers and output register.

Test Plan:
- Signed DIV 100/7 -> result 14, resp_valid 34 cycles after accept; same operands with rem_i=1 -> 2.
- Signed -7/2 -> quotient 0xFFFFFFFD (-3); rem_i=1 -> 0xFFFFFFFF (-1). DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- Divide by zero: 5/0 -> DIV gives 0xFFFFFFFF, REM gives 5, each 1 cycle after accept. Overflow 0x80000000/0xFFFFFFFF signed -> DIV gives 0x80000000, REM gives 0.
- Backpressure: hold resp_ready_i=0 for 5 cycles in DONE -> result_o and resp_valid_o stable; req_ready_o=0 throughout; IDLE one edge after resp_ready_i=1.
- Flush at CALC cycle 10 -> next cycle req_ready_o=1, busy_o=0, resp_valid_o never rises. A new 9/3 request then completes with 3.
- rst_n low mid-CALC -> outputs immediately at reset values; after release, 20/4 -> 5 with normal latency.
